// File: rtl/msg_scroll_scheduler_if.sv
// Purpose : bundles the requester inputs and the display outputs of msg_scroll_scheduler.
// Ports   : hello_req/prog_req/rate flow into the scheduler; seg/char_strobe/cur_msg flow out.
// Modports: master = requester/display side (testbench, pad ring); slave = the scheduler.
interface msg_scroll_scheduler_if #(
    parameter int RATE_W = 4
);
    logic              hello_req;
    logic              prog_req;
    logic [RATE_W-1:0] rate;
    logic [6:0]        seg;
    logic              char_strobe;
    logic [1:0]        cur_msg;

    modport master (
        output hello_req,
        output prog_req,
        output rate,
        input  seg,
        input  char_strobe,
        input  cur_msg
    );

    modport slave (
        input  hello_req,
        input  prog_req,
        input  rate,
        output seg,
        output char_strobe,
        output cur_msg
    );
endinterface

// File: rtl/msg_scroll_scheduler.sv
// Purpose : scrolls HELLO / PROG (each followed by a blank gap) onto a 7-segment digit, one char per 2^rate clocks.
// Latency : one clock from a request seen in IDLE to the first character on seg; all outputs registered.
// Backpr. : none; requests are level-sensitive and only sampled in IDLE and at the end of the gap.
// Ports   : clk, reset_n (async, active-low); bus.slave carries hello_req, prog_req, rate in and
//           seg {g,f,e,d,c,b,a}, char_strobe, cur_msg (00 none, 01 HELLO, 10 PROG) out.
module msg_scroll_scheduler #(
    parameter int PRESCALE_W = 16,
    parameter int RATE_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    msg_scroll_scheduler_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] MSG_NONE  = 2'b00;
    localparam logic [1:0] MSG_HELLO = 2'b01;
    localparam logic [1:0] MSG_PROG  = 2'b10;

    localparam logic [6:0] CH_H     = 7'h76;
    localparam logic [6:0] CH_E     = 7'h79;
    localparam logic [6:0] CH_L     = 7'h38;
    localparam logic [6:0] CH_O     = 7'h3F;
    localparam logic [6:0] CH_P     = 7'h73;
    localparam logic [6:0] CH_R     = 7'h50;
    localparam logic [6:0] CH_G     = 7'h3D;
    localparam logic [6:0] CH_BLANK = 7'h00;

    logic [1:0]            state;
    logic [2:0]            char_idx;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic [6:0]            seg_q;
    logic                  strobe_q;
    logic [1:0]            cur_msg_q;

    logic [RATE_W-1:0]     rate;
    logic [PRESCALE_W-1:0] limit;
    logic                  tick;
    logic [1:0]            winner;
    logic [2:0]            last_idx;

    function automatic logic [6:0] glyph(input logic [1:0] msg, input logic [2:0] idx);
        logic [6:0] g;
        g = CH_BLANK;
        if (msg == MSG_HELLO) begin
            case (idx)
                3'd0:    g = CH_H;
                3'd1:    g = CH_E;
                3'd2:    g = CH_L;
                3'd3:    g = CH_L;
                3'd4:    g = CH_O;
                default: g = CH_BLANK;
            endcase
        end else if (msg == MSG_PROG) begin
            case (idx)
                3'd0:    g = CH_P;
                3'd1:    g = CH_R;
                3'd2:    g = CH_O;
                3'd3:    g = CH_G;
                default: g = CH_BLANK;
            endcase
        end
        return g;
    endfunction

    assign rate = bus.rate;

    // ">=" rather than "==": if rate drops mid-period the count may already be past
    // the new limit, and it must tick at once instead of wrapping the counter.
    assign limit = (PRESCALE_W'(1) << rate) - PRESCALE_W'(1);
    assign tick  = (presc_cnt >= limit);

    // PROG wins over HELLO whenever both are asserted at an arbitration point.
    assign winner   = bus.prog_req  ? MSG_PROG  :
                      bus.hello_req ? MSG_HELLO : MSG_NONE;
    assign last_idx = (cur_msg_q == MSG_PROG) ? 3'd3 : 3'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            char_idx  <= 3'd0;
            presc_cnt <= '0;
            seg_q     <= CH_BLANK;
            strobe_q  <= 1'b0;
            cur_msg_q <= MSG_NONE;
        end else begin
            strobe_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    presc_cnt <= '0;
                    seg_q     <= CH_BLANK;
                    if (winner != MSG_NONE) begin
                        state     <= ST_SHOW;
                        char_idx  <= 3'd0;
                        cur_msg_q <= winner;
                        seg_q     <= glyph(winner, 3'd0);
                        strobe_q  <= 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (tick) begin
                        presc_cnt <= '0;
                        strobe_q  <= 1'b1;
                        if (char_idx == last_idx) begin
                            state <= ST_GAP;
                            seg_q <= CH_BLANK;
                        end else begin
                            char_idx <= char_idx + 3'd1;
                            seg_q    <= glyph(cur_msg_q, char_idx + 3'd1);
                        end
                    end else begin
                        presc_cnt <= presc_cnt + PRESCALE_W'(1);
                    end
                end

                ST_GAP: begin
                    if (tick) begin
                        presc_cnt <= '0;
                        char_idx  <= 3'd0;
                        if (winner != MSG_NONE) begin
                            // Back-to-back message: first char appears with no idle cycle.
                            state     <= ST_SHOW;
                            cur_msg_q <= winner;
                            seg_q     <= glyph(winner, 3'd0);
                            strobe_q  <= 1'b1;
                        end else begin
                            // Falling back to IDLE is silent: no strobe, blank display.
                            state     <= ST_IDLE;
                            cur_msg_q <= MSG_NONE;
                            seg_q     <= CH_BLANK;
                        end
                    end else begin
                        presc_cnt <= presc_cnt + PRESCALE_W'(1);
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    char_idx  <= 3'd0;
                    presc_cnt <= '0;
                    seg_q     <= CH_BLANK;
                    cur_msg_q <= MSG_NONE;
                end
            endcase
        end
    end

    assign bus.seg         = seg_q;
    assign bus.char_strobe = strobe_q;
    assign bus.cur_msg     = cur_msg_q;
endmodule
